// File: rtl/adc_align_pkg.sv
// Shared types and constants for the ADC lane word-alignment controller.
package adc_align_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    SLIP,
    LOCKED,
    FAIL
  } align_state_t;

  localparam int unsigned ADC_WORD_W = 8;
  localparam logic [ADC_WORD_W-1:0] FRAME_PATTERN = 8'hF0;

endpackage

// File: rtl/bitslip_align_ctrl.sv
// ISERDES word-alignment controller: slips until data_i matches PATTERN, then LOCKED or FAIL.
// Optional lock monitor with automatic realign enabled by defining BITSLIP_MONITOR_EN.
module bitslip_align_ctrl
  import adc_align_pkg::*;
#(
  parameter int unsigned WIDTH          = ADC_WORD_W,
  parameter logic [WIDTH-1:0] PATTERN   = FRAME_PATTERN,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned MATCH_COUNT    = 16,
  parameter int unsigned MAX_SLIPS      = 8,
  parameter int unsigned MISS_LIMIT     = 4
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           start,
  input  logic [WIDTH-1:0]               data_i,
  output logic                           bitslip,
  output logic                           busy,
  output logic                           locked,
  output logic                           fail,
  output logic                           lock_lost,
  output logic [$clog2(MAX_SLIPS+1)-1:0] slip_count
);

  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned MATCH_W  = $clog2(MATCH_COUNT + 1);
  localparam int unsigned SLIP_W   = $clog2(MAX_SLIPS + 1);

  if (SETTLE_CYCLES < 2 || MATCH_COUNT < 1 || MAX_SLIPS < 1 || MISS_LIMIT < 1) begin : g_bad_params
    $error("bitslip_align_ctrl: illegal parameter combination");
  end

  align_state_t        state_q, state_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
  logic [SLIP_W-1:0]   slip_cnt_q, slip_cnt_d;
  logic                armed_q, armed_d;
  logic                bitslip_q, bitslip_d;
  logic                busy_q, busy_d;
  logic                locked_q, locked_d;
  logic                fail_q, fail_d;
  logic                lock_lost_d;
  logic                start_ok;

`ifdef BITSLIP_MONITOR_EN
  localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
  logic              lock_lost_q;
`endif

  // armed_q stays low for the first edge after reset so a start held across release is ignored
  assign armed_d  = 1'b1;
  assign start_ok = start & armed_q;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    match_cnt_d  = match_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    lock_lost_d  = 1'b0;
`ifdef BITSLIP_MONITOR_EN
    miss_cnt_d   = miss_cnt_q;
`endif
    unique case (state_q)
      IDLE, FAIL: begin
        if (start_ok) begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
          match_cnt_d  = '0;
          slip_cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          state_d     = CHECK;
          match_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
        end
      end
      CHECK: begin
        if (match_cnt_q == MATCH_W'(MATCH_COUNT)) begin
          state_d = LOCKED;
`ifdef BITSLIP_MONITOR_EN
          miss_cnt_d = '0;
`endif
        end else if (data_i == PATTERN) begin
          match_cnt_d = match_cnt_q + MATCH_W'(1);
        end else begin
          match_cnt_d = '0;
          if (slip_cnt_q == SLIP_W'(MAX_SLIPS)) begin
            state_d = FAIL;
          end else begin
            state_d    = SLIP;
            slip_cnt_d = slip_cnt_q + SLIP_W'(1);
          end
        end
      end
      SLIP: begin
        state_d      = SETTLE;
        settle_cnt_d = '0;
      end
      LOCKED: begin
        if (start_ok) begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
          match_cnt_d  = '0;
          slip_cnt_d   = '0;
        end
`ifdef BITSLIP_MONITOR_EN
        else if (data_i != PATTERN) begin
          if (miss_cnt_q == MISS_W'(MISS_LIMIT - 1)) begin
            lock_lost_d  = 1'b1;
            state_d      = SETTLE;
            settle_cnt_d = '0;
            match_cnt_d  = '0;
            slip_cnt_d   = '0;
            miss_cnt_d   = '0;
          end else begin
            miss_cnt_d = miss_cnt_q + MISS_W'(1);
          end
        end else begin
          miss_cnt_d = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with state_q
  always_comb begin
    bitslip_d = (state_d == SLIP);
    busy_d    = (state_d == SETTLE) || (state_d == CHECK) || (state_d == SLIP);
    locked_d  = (state_d == LOCKED);
    fail_d    = (state_d == FAIL);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      match_cnt_q  <= '0;
      slip_cnt_q   <= '0;
      armed_q      <= 1'b0;
      bitslip_q    <= 1'b0;
      busy_q       <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      match_cnt_q  <= match_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      armed_q      <= armed_d;
      bitslip_q    <= bitslip_d;
      busy_q       <= busy_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
    end
  end

`ifdef BITSLIP_MONITOR_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      miss_cnt_q  <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      miss_cnt_q  <= miss_cnt_d;
      lock_lost_q <= lock_lost_d;
    end
  end
  assign lock_lost = lock_lost_q;
`else
  assign lock_lost = lock_lost_d;
`endif

  assign bitslip    = bitslip_q;
  assign busy       = busy_q;
  assign locked     = locked_q;
  assign fail       = fail_q;
  assign slip_count = slip_cnt_q;

endmodule

// File: tb/tb_bitslip_align_ctrl.sv
// Directed bench for bitslip_align_ctrl with a rotating-word ISERDES model (slip takes effect 2 cycles later).
module tb_bitslip_align_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       start;
  logic [7:0] data_i;
  logic       bitslip, busy, locked, fail, lock_lost;
  logic [3:0] slip_count;

  int   vec = 0;
  int   miss = 0;
  int   cyc = 0;
  int   pos = 0;
  int   pulses = 0;
  int   last_pulse = -1;
  int   first_pulse = -1;
  int   corrupt_cyc = -1;
  int   base = 0;
  bit   stuck = 0;
  bit   force_bad = 0;
  logic [2:0] pipe = '0;

  bitslip_align_ctrl #(
    .WIDTH(8), .PATTERN(8'hF0), .SETTLE_CYCLES(4),
    .MATCH_COUNT(16), .MAX_SLIPS(8), .MISS_LIMIT(4)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .data_i(data_i),
    .bitslip(bitslip), .busy(busy), .locked(locked), .fail(fail),
    .lock_lost(lock_lost), .slip_count(slip_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] rotw(input int p);
    logic [15:0] w;
    w = {8'hF0, 8'hF0};
    w = w << p;
    return w[15:8];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_data();
    if (stuck || force_bad || cyc == corrupt_cyc) data_i = 8'h00;
    else data_i = rotw(pos);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    pipe = {pipe[1:0], bitslip};
    if (pipe[2]) pos = (pos + 1) % 8;
    if (bitslip) begin
      pulses++;
      if (first_pulse < 0) first_pulse = cyc;
      if (last_pulse >= 0) check("slip_gap_ge6", 32'(cyc - last_pulse >= 6), 1);
      last_pulse = cyc;
    end
    drive_data();
  endtask

  task automatic new_attempt(input int p);
    pos = p; pipe = '0; pulses = 0; last_pulse = -1; first_pulse = -1;
    stuck = 0; force_bad = 0; corrupt_cyc = -1;
    drive_data();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    base = cyc;
  endtask

  initial begin
    RST_N = 1'b0; start = 1'b0; data_i = 8'h00;
    #12;
    check("rst_bitslip", bitslip, 0);
    check("rst_busy", busy, 0);
    check("rst_locked", locked, 0);
    check("rst_fail", fail, 0);
    check("rst_slip_count", slip_count, 0);
    check("rst_lock_lost", lock_lost, 0);

    // start held across reset release is ignored
    @(posedge CLK); #1;
    RST_N = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("start_at_release_busy", busy, 0);
    tick();
    check("start_at_release_busy2", busy, 0);

    // T1: aligned lane locks at edge 21
    new_attempt(0);
    start_pulse();
    check("t1_busy", busy, 1);
    repeat (20) tick();
    check("t1_locked_e20", locked, 0);
    tick();
    check("t1_locked_e21", locked, 1);
    check("t1_busy_done", busy, 0);
    check("t1_slip_count", slip_count, 0);
    check("t1_pulses", pulses, 0);

    // T2: offset of 3 positions, plus a start while busy that must be ignored
    new_attempt(5);
    start_pulse();
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 200 && !locked; i++) tick();
    check("t2_locked", locked, 1);
    check("t2_lock_edge", cyc - base, 39);
    check("t2_first_pulse", first_pulse - base, 5);
    check("t2_slip_count", slip_count, 3);
    check("t2_pulses", pulses, 3);

    // T3: stuck lane exhausts all slips
    new_attempt(0);
    stuck = 1; drive_data();
    start_pulse();
    for (int i = 0; i < 300 && !fail; i++) tick();
    check("t3_fail", fail, 1);
    check("t3_fail_edge", cyc - base, 53);
    check("t3_busy", busy, 0);
    check("t3_locked", locked, 0);
    check("t3_slip_count", slip_count, 8);
    check("t3_pulses", pulses, 8);

    // T4: one corrupt word on the 10th match forces a slip and a full rotation
    new_attempt(0);
    corrupt_cyc = cyc + 14;
    start_pulse();
    repeat (21) tick();
    check("t4_no_early_lock", locked, 0);
    check("t4_first_pulse", first_pulse - base, 14);
    for (int i = 0; i < 300 && !locked; i++) tick();
    check("t4_locked", locked, 1);
    check("t4_lock_edge", cyc - base, 78);
    check("t4_slip_count", slip_count, 8);
    check("t4_pulses", pulses, 8);

    // T5a: reset during SETTLE clears outputs immediately
    new_attempt(0);
    start_pulse();
    tick(); tick();
    #2 RST_N = 1'b0;
    #1;
    check("t5a_busy", busy, 0);
    check("t5a_locked", locked, 0);
    check("t5a_slip_count", slip_count, 0);
    #2 RST_N = 1'b1;
    tick();

    // T5b: reset during the SLIP cycle drops bitslip without a clock edge
    new_attempt(5);
    start_pulse();
    for (int i = 0; i < 50 && !bitslip; i++) tick();
    check("t5b_bitslip_seen", bitslip, 1);
    #2 RST_N = 1'b0;
    #1;
    check("t5b_bitslip_async", bitslip, 0);
    check("t5b_busy", busy, 0);
    check("t5b_slip_count", slip_count, 0);
    #2 RST_N = 1'b1;
    tick();
    new_attempt(5);
    start_pulse();
    for (int i = 0; i < 200 && !locked; i++) tick();
    check("t5_relock", locked, 1);
    check("t5_relock_slips", slip_count, 3);

    // T6: lock monitor (realign only in the monitor build)
    new_attempt(0);
    start_pulse();
    for (int i = 0; i < 100 && !locked; i++) tick();
    check("t6_locked", locked, 1);
    force_bad = 1; drive_data();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_3miss_locked", locked, 1);
      check("t6_3miss_lock_lost", lock_lost, 0);
    end
    force_bad = 0; drive_data();
    tick();
    check("t6_match_locked", locked, 1);
    force_bad = 1; drive_data();
    repeat (4) tick();
`ifdef BITSLIP_MONITOR_EN
    check("t6_lock_lost_pulse", lock_lost, 1);
    check("t6_unlocked", locked, 0);
    check("t6_realign_busy", busy, 1);
    check("t6_slip_cleared", slip_count, 0);
    force_bad = 0; drive_data();
    tick();
    check("t6_lock_lost_one_cycle", lock_lost, 0);
    for (int i = 0; i < 100 && !locked; i++) tick();
    check("t6_relocked", locked, 1);
`else
    check("t6_no_monitor_locked", locked, 1);
    check("t6_no_monitor_lock_lost", lock_lost, 0);
    tick();
    check("t6_no_monitor_locked2", locked, 1);
    check("t6_no_monitor_lock_lost2", lock_lost, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
